// File: rtl/byte_ram_pkg.sv
// Shared types and default parameters for the byte-lane RAM controller.
package byte_ram_pkg;

    localparam int unsigned DW_DEF     = 32;
    localparam int unsigned AW_DEF     = 4;
    localparam int unsigned DEPTH_DEF  = 16;
    localparam int unsigned RD_LAT_DEF = 1;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    // Expands up to 8 byte enables into a 64-bit bit mask; callers truncate to DW.
    function automatic logic [63:0] lane_mask(input logic [7:0] be);
        logic [63:0] m;
        m = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/byte_ram_ctrl_rd_pipe.sv
// Read-response delay line: LAT stages of valid+data with synchronous flush.
module rd_pipe
    import byte_ram_pkg::*;
#(
    parameter int unsigned DW  = DW_DEF,
    parameter int unsigned LAT = RD_LAT_DEF
) (
    input  logic          clk_i,
    input  logic          flush_i,
    input  logic          in_v_i,
    input  logic [DW-1:0] in_data_i,
    output logic          out_v_o,
    output logic [DW-1:0] out_data_o
);

    logic [LAT-1:0] v_q;
    logic [DW-1:0]  data_q [LAT];

    // Data stages load only behind a valid, so the last stage holds the most recent response.
    always_ff @(posedge clk_i) begin
        if (flush_i) begin
            v_q <= '0;
            for (int unsigned i = 0; i < LAT; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            v_q[0] <= in_v_i;
            if (in_v_i) begin
                data_q[0] <= in_data_i;
            end
            for (int unsigned i = 1; i < LAT; i++) begin
                v_q[i] <= v_q[i-1];
                if (v_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign out_v_o    = v_q[LAT-1];
    assign out_data_o = data_q[LAT-1];

endmodule

// File: rtl/byte_ram_ctrl.sv
// Byte-lane register RAM with post-reset clear sweep, pipelined reads and error pulse.
module byte_ram_ctrl
    import byte_ram_pkg::*;
#(
    parameter int unsigned DW     = DW_DEF,
    parameter int unsigned AW     = AW_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned RD_LAT = RD_LAT_DEF
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            wr_i,
    input  logic            rd_i,
    input  logic [DW/8-1:0] byte_i,
    input  logic [AW-1:0]   addr_i,
    input  logic [DW-1:0]   wdata_i,
    output logic            rdata_v_o,
    output logic [DW-1:0]   rdata_o,
    output logic            ready_o,
    output logic            err_o
);

    localparam int unsigned NB = DW / 8;

    state_e          state_q, state_d;
    logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
    logic            err_q, err_d;
    logic [DW-1:0]   mem_q [DEPTH];

    logic            addr_ok;
    logic            wr_acc;
    logic            rd_acc;
    logic [DW-1:0]   mask;
    logic [DW-1:0]   rd_word;

    assign ready_o = (state_q == READY);
    assign addr_ok = (32'(addr_i) < DEPTH);
    assign wr_acc  = wr_i & ready_o & addr_ok;
    assign rd_acc  = rd_i & ready_o;
    assign mask    = DW'(lane_mask(8'(byte_i)));
    // Read-first: the array is sampled before this cycle's write lands.
    assign rd_word = addr_ok ? (mem_q[addr_i] & mask) : '0;
    assign err_d   = (wr_i | rd_i) & ~(ready_o & addr_ok);

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == AW'(DEPTH - 1)) begin
                    state_d   = READY;
                    clr_cnt_d = '0;
                end
            end
            READY:   state_d = READY;
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            if (state_q == CLEAR) begin
                mem_q[clr_cnt_q] <= '0;
            end else if (wr_acc) begin
                for (int unsigned i = 0; i < NB; i++) begin
                    if (byte_i[i]) begin
                        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                    end
                end
            end
        end
    end

    rd_pipe #(
        .DW  (DW),
        .LAT (RD_LAT)
    ) u_rd_pipe (
        .clk_i      (clk_i),
        .flush_i    (!rst_ni),
        .in_v_i     (rd_acc),
        .in_data_i  (rd_word),
        .out_v_o    (rdata_v_o),
        .out_data_o (rdata_o)
    );

    assign err_o = err_q;

endmodule

// File: tb/tb_byte_ram_ctrl.sv
// Directed bench: default instance plus a DEPTH=12 / RD_LAT=3 instance.
module tb_byte_ram_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: defaults
    logic        rst0, wr0, rd0, v0, ready0, err0;
    logic [3:0]  be0, addr0;
    logic [31:0] wdata0, rdata0;

    // Instance 1: DEPTH=12, RD_LAT=3
    logic        rst1, wr1, rd1, v1, ready1, err1;
    logic [3:0]  be1, addr1;
    logic [31:0] wdata1, rdata1;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc;

    byte_ram_ctrl u_dut0 (
        .clk_i     (clk),
        .rst_ni    (rst0),
        .wr_i      (wr0),
        .rd_i      (rd0),
        .byte_i    (be0),
        .addr_i    (addr0),
        .wdata_i   (wdata0),
        .rdata_v_o (v0),
        .rdata_o   (rdata0),
        .ready_o   (ready0),
        .err_o     (err0)
    );

    byte_ram_ctrl #(
        .DW     (32),
        .AW     (4),
        .DEPTH  (12),
        .RD_LAT (3)
    ) u_dut1 (
        .clk_i     (clk),
        .rst_ni    (rst1),
        .wr_i      (wr1),
        .rd_i      (rd1),
        .byte_i    (be1),
        .addr_i    (addr1),
        .wdata_i   (wdata1),
        .rdata_v_o (v1),
        .rdata_o   (rdata1),
        .ready_o   (ready1),
        .err_o     (err1)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst0 = 1'b0; wr0 = 1'b0; rd0 = 1'b0; be0 = '0; addr0 = '0; wdata0 = '0;
        rst1 = 1'b0; wr1 = 1'b0; rd1 = 1'b0; be1 = '0; addr1 = '0; wdata1 = '0;
        step(); step(); step();

        check_eq("rst_ready",  ready0, 0);
        check_eq("rst_rdv",    v0,     0);
        check_eq("rst_rdata",  rdata0, 0);
        check_eq("rst_err",    err0,   0);

        // Release both resets; default instance needs exactly 16 clear cycles
        rst0 = 1'b1; rst1 = 1'b1;
        cyc = 0;
        while (!ready0 && cyc < 40) begin
            step();
            cyc++;
        end
        check_eq("clear_cycles", cyc, 16);

        // Cleared word reads zero, one-cycle latency
        rd0 = 1'b1; addr0 = 4'd5; be0 = 4'hF;
        step(); rd0 = 1'b0;
        check_eq("rd5_v",     v0,     1);
        check_eq("rd5_data",  rdata0, 32'h0);
        step();
        check_eq("rd5_v_drop", v0, 0);

        // Full write then read
        wr0 = 1'b1; addr0 = 4'd1; be0 = 4'hF; wdata0 = 32'h0000_0011;
        step(); wr0 = 1'b0;
        rd0 = 1'b1; addr0 = 4'd1; be0 = 4'hF;
        step(); rd0 = 1'b0;
        check_eq("rd1_v",    v0,     1);
        check_eq("rd1_data", rdata0, 32'h0000_0011);

        // Partial-lane write, then masked reads back to back
        wr0 = 1'b1; addr0 = 4'd2; be0 = 4'hF; wdata0 = 32'hAABB_CCDD;
        step();
        be0 = 4'h5; wdata0 = 32'h1122_3344;
        step(); wr0 = 1'b0;
        rd0 = 1'b1; addr0 = 4'd2; be0 = 4'hF;
        step();
        check_eq("rd2_full", rdata0, 32'hAA22_CC44);
        be0 = 4'h3;
        step(); rd0 = 1'b0;
        check_eq("rd2_mask_v", v0,     1);
        check_eq("rd2_mask",   rdata0, 32'h0000_CC44);
        step();
        check_eq("hold_v",     v0,     0);
        check_eq("hold_data",  rdata0, 32'h0000_CC44);

        // Byte enable zero leaves the word untouched
        wr0 = 1'b1; addr0 = 4'd2; be0 = 4'h0; wdata0 = 32'hFFFF_FFFF;
        step(); wr0 = 1'b0;
        check_eq("be0_err", err0, 0);
        rd0 = 1'b1; be0 = 4'hF;
        step(); rd0 = 1'b0;
        check_eq("be0_data", rdata0, 32'hAA22_CC44);

        // Same-cycle write/read: read-first
        wr0 = 1'b1; addr0 = 4'd3; be0 = 4'hF; wdata0 = 32'h7;
        step();
        rd0 = 1'b1; wdata0 = 32'h1;
        step(); wr0 = 1'b0;
        check_eq("rw_old", rdata0, 32'h7);
        step(); rd0 = 1'b0;
        check_eq("rw_new_v", v0,     1);
        check_eq("rw_new",   rdata0, 32'h1);

        // Instance 1: populate words 0..2
        check_eq("i1_ready", ready1, 1);
        wr1 = 1'b1; be1 = 4'hF;
        addr1 = 4'd0; wdata1 = 32'hA; step();
        addr1 = 4'd1; wdata1 = 32'hB; step();
        addr1 = 4'd2; wdata1 = 32'hC; step();
        // Out-of-range write
        addr1 = 4'd13; wdata1 = 32'hFF; step(); wr1 = 1'b0;
        check_eq("oor_wr_err", err1, 1);
        step();
        check_eq("oor_err_pulse", err1, 0);

        // Back-to-back reads with three-cycle latency
        rd1 = 1'b1; addr1 = 4'd0; step();
        check_eq("lat3_v_t1", v1, 0);
        addr1 = 4'd1; step();
        check_eq("lat3_v_t2", v1, 0);
        addr1 = 4'd2; step(); rd1 = 1'b0;
        check_eq("lat3_v0", v1, 1);
        check_eq("lat3_d0", rdata1, 32'hA);
        step();
        check_eq("lat3_v1", v1, 1);
        check_eq("lat3_d1", rdata1, 32'hB);
        step();
        check_eq("lat3_v2", v1, 1);
        check_eq("lat3_d2", rdata1, 32'hC);
        step();
        check_eq("lat3_end", v1, 0);

        // Out-of-range read: error plus zero response
        rd1 = 1'b1; addr1 = 4'd13; step(); rd1 = 1'b0;
        check_eq("oor_rd_err", err1, 1);
        step(); step();
        check_eq("oor_rd_v", v1, 1);
        check_eq("oor_rd_d", rdata1, 32'h0);

        // Reset with a read in flight
        rd1 = 1'b1; addr1 = 4'd1; step(); rd1 = 1'b0;
        rst1 = 1'b0; step();
        check_eq("flush_v",     v1,     0);
        check_eq("flush_rdata", rdata1, 32'h0);
        check_eq("flush_ready", ready1, 0);
        rst1 = 1'b1;
        // Read during clear
        rd1 = 1'b1; addr1 = 4'd0; step(); rd1 = 1'b0;
        check_eq("clr_rd_err", err1, 1);
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq("clr_rd_no_v", v1, 0);
        end
        check_eq("clr_err_pulse", err1, 0);
        cyc = 0;
        while (!ready1 && cyc < 40) begin
            step();
            cyc++;
        end
        check_eq("i1_reclear_ready", ready1, 1);
        rd1 = 1'b1; addr1 = 4'd1; step(); rd1 = 1'b0;
        step(); step();
        check_eq("reclear_d", rdata1, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/byte_ram_ctrl.md
BYTE_RAM_CTRL -- requirements
Module: byte_ram_ctrl

Interface
REQ-001 Parameter DW, default 32: data width in bits; SHALL be a multiple of 8, range 8..64.
REQ-002 Parameter AW, default 4: address width.
REQ-003 Parameter DEPTH, default 16: number of words; SHALL satisfy 1 <= DEPTH <= 2**AW.
REQ-004 Parameter RD_LAT, default 1: read latency in cycles, range 1..4.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 wr  input  1  write request, sampled each cycle.
REQ-008 rd  input  1  read request, sampled each cycle.
REQ-009 byte  input  DW/8  byte-lane enables; bit i covers wdata/rdata bits [8i+7:8i].
REQ-010 addr  input  AW  word address.
REQ-011 wdata  input  DW  write data.
REQ-012 rdata_v  output  1  read data valid, one-cycle pulse per accepted read.
REQ-013 rdata  output  DW  read data.
REQ-014 ready  output  1  high when the block accepts requests.
REQ-015 err  output  1  one-cycle error pulse.

Function
REQ-016 FSM states: CLEAR, READY; CLEAR entered on reset, zeroes word 0..DEPTH-1 one word per cycle, then READY; CLEAR lasts exactly DEPTH cycles.
REQ-017 ready SHALL be high only in READY.
REQ-018 Write accepted (wr=1, ready=1, addr<DEPTH) in cycle T: lanes with byte[i]=1 updated; other lanes unchanged; byte=0 leaves word unchanged, no error.
REQ-019 Read accepted (rd=1, ready=1) in cycle T: rdata_v=1 and rdata valid in cycle T+RD_LAT exactly.
REQ-020 rdata lanes with byte[i]=0 at issue SHALL be 0.
REQ-021 Reads fully pipelined: one read per cycle sustained, responses in issue order, no bubbles.
REQ-022 wr and rd same cycle, same address: both accepted; read returns pre-write contents (read-first); read at T+1 sees new data.
REQ-023 addr >= DEPTH on wr: write suppressed, err=1 in T+1.
REQ-024 addr >= DEPTH on rd: rdata_v still pulses at T+RD_LAT with rdata=0; err=1 in T+1.
REQ-025 wr or rd while ready=0: request ignored, no rdata_v, err=1 in T+1.
REQ-026 err for multiple causes in one cycle SHALL still be a single one-cycle pulse.
REQ-027 When rdata_v=0, rdata SHALL hold its last valid value.

Reset
REQ-028 rst_n=0 at a rising edge: rdata_v=0, rdata=0, err=0, ready=0, FSM to CLEAR at word 0, read pipeline flushed.
REQ-029 Reset mid-clear or mid-read: in-flight reads discarded (no rdata_v); clear restarts from word 0.
REQ-030 Reset held multiple cycles: outputs stay at reset values; CLEAR's DEPTH-cycle count starts on the first cycle rst_n=1.

Structure
REQ-031 Package byte_ram_pkg SHALL hold the FSM state typedef (CLEAR, READY) and default values of DW, AW, DEPTH, RD_LAT.
REQ-032 Sub-module rd_pipe SHALL implement the RD_LAT-stage valid+data delay line with synchronous flush.
REQ-033 Storage SHALL be a register array of DEPTH x DW, no vendor primitives.

Verification
REQ-034 Reset then wait: ready rises exactly 16 cycles after rst_n=1 (defaults); read addr 5 -> rdata=0x00000000.
REQ-035 Write addr 1 byte=F wdata=0x00000011; read addr 1 byte=F -> rdata_v at T+1, rdata=0x00000011.
REQ-036 Write addr 2 0xAABBCCDD byte=F, then byte=0x5 wdata=0x11223344; read byte=F -> 0xAA22CC44; read byte=0x3 -> 0x0000CC44.
REQ-037 RD_LAT=3, reads addr 0,1,2 back-to-back -> three consecutive rdata_v pulses starting T+3, in order.
REQ-038 DEPTH=12: write addr 13 -> err pulse, memory unchanged; rd during CLEAR -> err, no rdata_v.
REQ-039 Same-cycle wr 0x1 / rd on addr 3 holding 0x7 -> rdata=0x7; next read -> 0x1; reset with read in flight -> no rdata_v.
